// File: rtl/stereo_decorrelator_if.sv
// Sample-stream and PCM-pair bundle between the subframe decoder, the
// stereo decorrelator and the output stage.
interface stereo_decorrelator_if #(
  parameter int SAMPLE_W = 16
);
  logic                       iStart;
  logic [3:0]                 iChanAssign;
  logic [15:0]                iBlockSize;
  logic                       iSampleValid;
  logic                       iChannel;
  logic signed [SAMPLE_W:0]   iSample;
  logic                       oValid;
  logic signed [SAMPLE_W-1:0] oLeft;
  logic signed [SAMPLE_W-1:0] oRight;
  logic                       oFrameDone;
  logic                       oBusy;
  logic                       oError;

  modport master (
    output iStart, iChanAssign, iBlockSize, iSampleValid, iChannel, iSample,
    input  oValid, oLeft, oRight, oFrameDone, oBusy, oError
  );

  modport slave (
    input  iStart, iChanAssign, iBlockSize, iSampleValid, iChannel, iSample,
    output oValid, oLeft, oRight, oFrameDone, oBusy, oError
  );
endinterface

// File: rtl/stereo_decorrelator.sv
// Rebuilds left/right PCM pairs from a FLAC frame's channel-0 then channel-1
// sample stream, buffering channel 0 and undoing the inter-channel coding.
module stereo_decorrelator #(
  parameter int SAMPLE_W  = 16,
  parameter int MAX_BLOCK = 4608,
  parameter int ADDR_W    = 13
) (
  input  logic                 iClock,
  input  logic                 iReset,
  stereo_decorrelator_if.slave sd
);

  localparam int CW = SAMPLE_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    MERGE = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          idx_q, idx_d;
  logic [3:0]                 asg_q, asg_d;
  logic [15:0]                bs_q, bs_d;
  logic                       busy_q, busy_d;
  logic                       err_q, err_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;
  logic signed [SAMPLE_W-1:0] left_q, left_d;
  logic signed [SAMPLE_W-1:0] right_q, right_d;

  logic signed [SAMPLE_W:0]   mem [MAX_BLOCK];
  logic signed [SAMPLE_W:0]   rd_q;

  logic                       is_mono_s, exp_chan_s, accept_s, last_s, we_s;
  logic                       code_ok_s, size_ok_s;
  logic signed [CW-1:0]       c0_s, c1_s, m2_s, sum_s, dif_s, lf_s, rf_s;

  // Start legality, sample acceptance and end-of-channel detection.
  always_comb begin
    case (sd.iChanAssign)
      4'd0, 4'd1, 4'd8, 4'd9, 4'd10: code_ok_s = 1'b1;
      default:                       code_ok_s = 1'b0;
    endcase
    size_ok_s  = (sd.iBlockSize != 16'd0) && (32'(sd.iBlockSize) <= 32'(MAX_BLOCK));
    is_mono_s  = (asg_q == 4'd0);
    exp_chan_s = (state_q == MERGE) && !is_mono_s;
    accept_s   = sd.iSampleValid && !sd.iStart && (state_q != IDLE) &&
                 (sd.iChannel == exp_chan_s);
    last_s     = (32'(idx_q) == (32'(bs_q) - 32'd1));
    we_s       = accept_s && (state_q == FILL);
  end

  // Inverse decorrelation at two bits of headroom, truncated on output.
  always_comb begin
    c0_s  = is_mono_s ? CW'(sd.iSample) : CW'(rd_q);
    c1_s  = CW'(sd.iSample);
    m2_s  = (c0_s <<< 1) | CW'(c1_s[0]);
    sum_s = m2_s + c1_s;
    dif_s = m2_s - c1_s;
    case (asg_q)
      4'd1: begin
        lf_s = c0_s;
        rf_s = c1_s;
      end
      4'd8: begin
        lf_s = c0_s;
        rf_s = c0_s - c1_s;
      end
      4'd9: begin
        lf_s = c0_s + c1_s;
        rf_s = c1_s;
      end
      4'd10: begin
        lf_s = sum_s >>> 1;
        rf_s = dif_s >>> 1;
      end
      default: begin
        lf_s = c0_s;
        rf_s = c0_s;
      end
    endcase
  end

  // Next-state logic: a start always wins over a same-cycle sample.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asg_d   = asg_q;
    bs_d    = bs_q;
    busy_d  = busy_q;
    err_d   = err_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    left_d  = left_q;
    right_d = right_q;
    if (sd.iStart) begin
      idx_d = '0;
      if (code_ok_s && size_ok_s) begin
        err_d   = 1'b0;
        asg_d   = sd.iChanAssign;
        bs_d    = sd.iBlockSize;
        busy_d  = 1'b1;
        state_d = (sd.iChanAssign == 4'd0) ? MERGE : FILL;
      end else begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end else if (sd.iSampleValid) begin
      if (!accept_s) begin
        err_d = 1'b1;
      end else if (state_q == FILL) begin
        if (last_s) begin
          idx_d   = '0;
          state_d = MERGE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end else begin
        valid_d = 1'b1;
        left_d  = lf_s[SAMPLE_W-1:0];
        right_d = rf_s[SAMPLE_W-1:0];
        if (last_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      asg_q   <= 4'd0;
      bs_q    <= 16'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asg_q   <= asg_d;
      bs_q    <= bs_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  // Channel-0 buffer. Reading at the next index keeps rd_q aligned with
  // idx_q, so back-to-back merges see their partner with no bubble; the
  // bypass covers a one-sample block whose write and read coincide.
  always_ff @(posedge iClock) begin
    if (we_s) begin
      mem[idx_q] <= sd.iSample;
    end
    rd_q <= (we_s && (idx_q == idx_d)) ? sd.iSample : mem[idx_d];
  end

  assign sd.oValid     = valid_q;
  assign sd.oLeft      = left_q;
  assign sd.oRight     = right_q;
  assign sd.oFrameDone = done_q;
  assign sd.oBusy      = busy_q;
  assign sd.oError     = err_q;

endmodule

// File: tb/tb_stereo_decorrelator.sv
// Self-checking bench for stereo_decorrelator: directed frames plus random
// stereo frames checked by re-encoding known left/right pairs.
module tb_stereo_decorrelator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  stereo_decorrelator_if #(.SAMPLE_W(16)) sd ();

  stereo_decorrelator #(
    .SAMPLE_W (16),
    .MAX_BLOCK(4608),
    .ADDR_W   (13)
  ) dut (
    .iClock(clk),
    .iReset(rst),
    .sd    (sd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit ch, input int s);
    sd.iSampleValid = v;
    sd.iChannel     = ch;
    sd.iSample      = 17'(s);
    tick();
    sd.iSampleValid = 1'b0;
  endtask

  task automatic start(input int asg, input int bs);
    sd.iStart      = 1'b1;
    sd.iChanAssign = 4'(asg);
    sd.iBlockSize  = 16'(bs);
    tick();
    sd.iStart = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone, sd.oBusy, sd.oError} !== 36'd0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%0b l=%0d r=%0d d=%0b b=%0b e=%0b want all 0",
               sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone, sd.oBusy, sd.oError);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_left_side();
    int c1v[2] = '{1500, 5};
    int el[2]  = '{1000, 5};
    int er[2]  = '{-500, 0};
    start(8, 2);
    drive(1'b1, 1'b0, 1000);
    drive(1'b1, 1'b0, 5);
    checks++;
    if (sd.oValid !== 1'b0 || sd.oBusy !== 1'b1) begin
      fails++;
      $display("FAIL ls_fill_quiet: got v=%0b b=%0b want v=0 b=1", sd.oValid, sd.oBusy);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, c1v[i]);
      checks++;
      if ({sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone} !== {1'b1, 16'(el[i]), 16'(er[i]), (i == 1)}) begin
        fails++;
        $display("FAIL ls_pair%0d: got v=%0b l=%0d r=%0d d=%0b want v=1 l=%0d r=%0d d=%0b",
                 i, sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone, el[i], er[i], i == 1);
      end
    end
    tick();
    checks++;
    if ({sd.oValid, sd.oFrameDone, sd.oBusy} !== 3'b000) begin
      fails++;
      $display("FAIL ls_after: got v=%0b d=%0b b=%0b want 000", sd.oValid, sd.oFrameDone, sd.oBusy);
    end
  endtask

  task automatic test_mid_side_one();
    start(10, 1);
    drive(1'b1, 1'b0, 100);
    drive(1'b1, 1'b1, -3);
    checks++;
    if ({sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone} !== {1'b1, 16'sd99, 16'sd102, 1'b1}) begin
      fails++;
      $display("FAIL ms_bs1: got v=%0b l=%0d r=%0d d=%0b want 1 99 102 1",
               sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone);
    end
  endtask

  task automatic test_right_side();
    start(9, 1);
    drive(1'b1, 1'b0, -20);
    drive(1'b1, 1'b1, 7);
    checks++;
    if ({sd.oValid, sd.oLeft, sd.oRight} !== {1'b1, -16'sd13, 16'sd7}) begin
      fails++;
      $display("FAIL rs: got v=%0b l=%0d r=%0d want 1 -13 7", sd.oValid, sd.oLeft, sd.oRight);
    end
  endtask

  task automatic test_back_to_back();
    int s[4] = '{1, -1, 32767, -32768};
    start(0, 4);
    for (int i = 0; i < 4; i++) begin
      sd.iSampleValid = 1'b1;
      sd.iChannel     = 1'b0;
      sd.iSample      = 17'(s[i]);
      tick();
      checks++;
      if ({sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone} !== {1'b1, 16'(s[i]), 16'(s[i]), (i == 3)}) begin
        fails++;
        $display("FAIL mono%0d: got v=%0b l=%0d r=%0d d=%0b want 1 %0d %0d %0b",
                 i, sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone, s[i], s[i], i == 3);
      end
    end
    sd.iSampleValid = 1'b0;
    start(0, 1);
    checks++;
    if (sd.oBusy !== 1'b1) begin
      fails++;
      $display("FAIL start_on_done: got busy=%0b want 1", sd.oBusy);
    end
    drive(1'b1, 1'b0, 42);
  endtask

  task automatic test_random_stereo();
    int modes[4] = '{1, 8, 9, 10};
    int el[24], er[24], c0[24], c1[24];
    logic signed [15:0] t;
    for (int f = 0; f < 16; f++) begin
      int mode = modes[f % 4];
      int bs   = int'($urandom_range(1, 24));
      for (int i = 0; i < bs; i++) begin
        t = 16'($urandom); el[i] = t;
        t = 16'($urandom); er[i] = t;
        case (mode)
          1:  begin c0[i] = el[i];                   c1[i] = er[i];         end
          8:  begin c0[i] = el[i];                   c1[i] = el[i] - er[i]; end
          9:  begin c0[i] = el[i] - er[i];           c1[i] = er[i];         end
          default: begin c0[i] = (el[i] + er[i]) >>> 1; c1[i] = el[i] - er[i]; end
        endcase
      end
      start(mode, bs);
      for (int i = 0; i < bs; i++) begin
        repeat ($urandom_range(0, 1)) drive(1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, c0[i]);
        checks++;
        if (sd.oValid !== 1'b0) begin
          fails++;
          $display("FAIL rnd_fill_quiet f%0d i%0d: got v=%0b want 0", f, i, sd.oValid);
        end
      end
      for (int i = 0; i < bs; i++) begin
        repeat ($urandom_range(0, 1)) drive(1'b0, 1'b1, 0);
        drive(1'b1, 1'b1, c1[i]);
        checks++;
        if ({sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone} !== {1'b1, 16'(el[i]), 16'(er[i]), (i == bs - 1)}) begin
          fails++;
          $display("FAIL rnd m%0d f%0d i%0d: got v=%0b l=%0d r=%0d d=%0b want 1 %0d %0d %0b",
                   mode, f, i, sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone, el[i], er[i], i == bs - 1);
        end
      end
    end
  endtask

  task automatic test_full_block();
    int bad = 0;
    start(1, 4608);
    for (int i = 0; i < 4608; i++) begin
      drive(1'b1, 1'b0, i - 2304);
      if (i == 100) begin
        drive(1'b1, 1'b1, 12345);
        checks++;
        if ({sd.oError, sd.oValid, sd.oBusy} !== 3'b101) begin
          fails++;
          $display("FAIL inject_ch1: got e=%0b v=%0b b=%0b want 1 0 1", sd.oError, sd.oValid, sd.oBusy);
        end
      end
    end
    for (int i = 0; i < 4608; i++) begin
      drive(1'b1, 1'b1, 2000 - i);
      checks++;
      if ({sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone} !==
          {1'b1, 16'(i - 2304), 16'(2000 - i), (i == 4607)}) begin
        fails++;
        bad++;
        if (bad < 5)
          $display("FAIL full_pair%0d: got v=%0b l=%0d r=%0d d=%0b want 1 %0d %0d %0b",
                   i, sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone, i - 2304, 2000 - i, i == 4607);
      end
    end
    checks++;
    if ({sd.oError, sd.oBusy} !== 2'b10) begin
      fails++;
      $display("FAIL full_end: got e=%0b b=%0b want e=1 b=0", sd.oError, sd.oBusy);
    end
  endtask

  task automatic test_errors();
    start(4, 10);
    checks++;
    if ({sd.oError, sd.oBusy} !== 2'b10) begin
      fails++;
      $display("FAIL reserved4: got e=%0b b=%0b want 1 0", sd.oError, sd.oBusy);
    end
    start(1, 3);
    checks++;
    if ({sd.oError, sd.oBusy} !== 2'b01) begin
      fails++;
      $display("FAIL legal_clears: got e=%0b b=%0b want 0 1", sd.oError, sd.oBusy);
    end
    start(1, 0);
    checks++;
    if ({sd.oError, sd.oBusy} !== 2'b10) begin
      fails++;
      $display("FAIL size0: got e=%0b b=%0b want 1 0", sd.oError, sd.oBusy);
    end
    start(1, 4609);
    checks++;
    if ({sd.oError, sd.oBusy} !== 2'b10) begin
      fails++;
      $display("FAIL size4609: got e=%0b b=%0b want 1 0", sd.oError, sd.oBusy);
    end
    start(1, 1);
    drive(1'b1, 1'b0, 11);
    drive(1'b1, 1'b1, 22);
    drive(1'b1, 1'b0, 5);
    checks++;
    if ({sd.oError, sd.oValid} !== 2'b10) begin
      fails++;
      $display("FAIL idle_sample: got e=%0b v=%0b want 1 0", sd.oError, sd.oValid);
    end
    // A start coinciding with a sample must drop the sample.
    start(1, 2);
    drive(1'b1, 1'b0, 50);
    sd.iSampleValid = 1'b1;
    sd.iChannel     = 1'b0;
    sd.iSample      = 17'(999);
    start(1, 2);
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b0, 2);
    drive(1'b1, 1'b1, 3);
    checks++;
    if ({sd.oValid, sd.oLeft, sd.oRight} !== {1'b1, 16'sd1, 16'sd3}) begin
      fails++;
      $display("FAIL start_drops_sample: got v=%0b l=%0d r=%0d want 1 1 3", sd.oValid, sd.oLeft, sd.oRight);
    end
    drive(1'b1, 1'b1, 4);
  endtask

  task automatic test_abort_and_reset();
    start(1, 4);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 100 + i);
    drive(1'b1, 1'b1, 7);
    drive(1'b1, 1'b1, 8);
    start(3, 4);
    checks++;
    if ({sd.oError, sd.oBusy, sd.oFrameDone, sd.oValid} !== 4'b1000) begin
      fails++;
      $display("FAIL abort_reserved: got e=%0b b=%0b d=%0b v=%0b want 1 0 0 0",
               sd.oError, sd.oBusy, sd.oFrameDone, sd.oValid);
    end
    drive(1'b1, 1'b1, 9);
    checks++;
    if ({sd.oValid, sd.oFrameDone} !== 2'b00) begin
      fails++;
      $display("FAIL abort_idle: got v=%0b d=%0b want 0 0", sd.oValid, sd.oFrameDone);
    end
    start(1, 2);
    checks++;
    if ({sd.oError, sd.oBusy} !== 2'b01) begin
      fails++;
      $display("FAIL restart_clears: got e=%0b b=%0b want 0 1", sd.oError, sd.oBusy);
    end
    drive(1'b1, 1'b0, 77);
    rst = 1'b1;
    #1;
    checks++;
    if ({sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone, sd.oBusy, sd.oError} !== 36'd0) begin
      fails++;
      $display("FAIL async_reset: got v=%0b l=%0d r=%0d d=%0b b=%0b e=%0b want all 0",
               sd.oValid, sd.oLeft, sd.oRight, sd.oFrameDone, sd.oBusy, sd.oError);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    sd.iStart       = 1'b0;
    sd.iChanAssign  = 4'd0;
    sd.iBlockSize   = 16'd0;
    sd.iSampleValid = 1'b0;
    sd.iChannel     = 1'b0;
    sd.iSample      = 17'd0;
    test_reset();
    test_left_side();
    test_mid_side_one();
    test_right_side();
    test_back_to_back();
    test_random_stereo();
    test_full_block();
    test_errors();
    test_abort_and_reset();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
